// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache block: machine word, RAM port status and the
// memory arbiter state encoding (shared by the arbiter and its bench).
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM port on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter grant state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
// Bundles the icache/dcache request signals and the single RAM port.
//   master : the arbiter side (drives load data, waits and the RAM request)
//   slave  : the caches + RAM side (drives requests, RAM status and read data)
//
// Handshake: a cache raises iREN / dREN / dWEN and holds address and data
// stable while its wait is high; the access completes in the single cycle in
// which its wait is low. Dropping every enable before that aborts the access.
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;
  import cpu_types_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/cache_mem_arbiter_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating counter of dcache grants won while the icache was waiting.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear to zero (wins over inc_i)
//   inc_i    : increment, saturating at all-ones
//   cnt_o    : current count
//   limit_o  : count has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module arb_starve_cnt
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX_V = '1;

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign limit_o = (cnt_q >= LIMIT_V);

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one RAM port between the instruction and data caches. The dcache has
// priority; a starvation counter forces an icache grant after STARVE_LIMIT
// dcache grants won while the icache was waiting. Grants are registered and
// held until the access completes (ACCESS) or the owner withdraws.
//   CLK, RST      : clock, synchronous active-high reset
//   bus (master)  : cache requests, waits/load data and the RAM port
//   state_o       : current grant state (debug)
//   starve_cnt_o  : starvation counter value (debug)
//   force_i_o     : forced-icache flag (debug)
// All bus outputs are combinational from the registered state and the current
// requests; ramstate only steers waits and next state, never the RAM enables.
// -----------------------------------------------------------------------------
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  cache_mem_arbiter_if.master     bus,
  output arb_state_t              state_o,
  output logic [STARVE_CNT_W-1:0] starve_cnt_o,
  output logic                    force_i_o
);

  arb_state_t state_q, state_d;
  logic       force_q, force_d;
  logic       cnt_clr, cnt_inc, cnt_limit;
  logic       d_req;

  assign d_req = bus.dREN | bus.dWEN;

  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (CLK),
    .rst     (RST),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .cnt_o   (starve_cnt_o),
    .limit_o (cnt_limit)
  );

  always_comb begin
    state_d      = state_q;
    // Latch the limit; the clear on icache grant below takes precedence.
    force_d      = force_q | cnt_limit;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    case (state_q)
      IDLE: begin
        // The forced flag only blocks the dcache while the icache is actually
        // asking, so a stale flag can never stall the dcache forever.
        if (d_req && !(force_q && bus.iREN)) begin
          state_d = DGNT;
          cnt_inc = bus.iREN;
        end else if (bus.iREN) begin
          state_d = IGNT;
          cnt_clr = 1'b1;
          force_d = 1'b0;
        end
      end

      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;               // withdrawn: abort
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait = 1'b0;
          state_d   = IDLE;
        end
        // FREE / BUSY / ERROR: hold and retry
      end

      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (bus.dWEN) begin
          bus.ramWEN = 1'b1;            // write wins over read
        end else begin
          bus.ramREN = bus.dREN;
        end
        if (!d_req) begin
          state_d = IDLE;               // withdrawn: abort
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      force_q <= force_d;
    end
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign state_o   = state_q;
  assign force_i_o = force_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A small RAM model answers every request with err_cfg ERROR
// cycles, then busy_cfg BUSY cycles, then ACCESS. Every completion pops the
// expected {dcache, load data} pair from exp_q.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic                    clk;
  logic                    rst;
  arb_state_t              state_o;
  logic [STARVE_CNT_W-1:0] starve_cnt_o;
  logic                    force_i_o;

  cache_mem_arbiter_if bif ();

  cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK          (clk),
    .RST          (rst),
    .bus          (bif),
    .state_o      (state_o),
    .starve_cnt_o (starve_cnt_o),
    .force_i_o    (force_i_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  int    busy_cfg;
  int    err_cfg;
  int    ram_cnt;
  word_t ram_data;

  assign bif.ramload = ram_data;

  always_comb begin
    bif.ramstate = FREE;
    if (bif.ramREN || bif.ramWEN) begin
      if (ram_cnt < err_cfg)                 bif.ramstate = ERROR;
      else if (ram_cnt < err_cfg + busy_cfg) bif.ramstate = BUSY;
      else                                   bif.ramstate = ACCESS;
    end
  end

  always @(posedge clk) begin
    if (rst || !(bif.ramREN || bif.ramWEN) || bif.ramstate == ACCESS) ram_cnt <= 0;
    else                                                              ram_cnt <= ram_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          tests_run;
  int          tests_failed;
  logic [32:0] exp_q[$];
  logic [32:0] sb_e;

  always @(negedge clk) begin
    if (!bif.dwait && !bif.iwait) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_both_waits_low: got iwait=0 dwait=0, want at most one low");
    end
    if (!bif.dwait) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_dcache_unexpected: got completion dload=%h, want none", bif.dload);
      end else begin
        sb_e = exp_q.pop_front();
        if ({1'b1, bif.dload} !== sb_e) begin
          tests_failed++;
          $display("FAIL sb_dcache: got {d,data}=%h, want %h", {1'b1, bif.dload}, sb_e);
        end
      end
    end
    if (!bif.iwait) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_icache_unexpected: got completion iload=%h, want none", bif.iload);
      end else begin
        sb_e = exp_q.pop_front();
        if ({1'b0, bif.iload} !== sb_e) begin
          tests_failed++;
          $display("FAIL sb_icache: got {d,data}=%h, want %h", {1'b0, bif.iload}, sb_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    bif.iREN = 1'b0; bif.dREN = 1'b0; bif.dWEN = 1'b0;
  endtask

  // Returns the cycle index (0 = request cycle) of the completion, or -1.
  task automatic wait_done(input bit is_d, input int budget, output int cyc);
    cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (is_d ? !bif.dwait : !bif.iwait) begin
        cyc = c;
        next_cycle();
        return;
      end
      next_cycle();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bif.iREN = 1'b1; bif.dREN = 1'b1; bif.iaddr = 32'h4; bif.daddr = 32'h8;
    next_cycle(); next_cycle();
    @(negedge clk);
    tests_run++;
    if (state_o !== IDLE || starve_cnt_o !== 4'd0 || force_i_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got st=%0d cnt=%0d f=%b, want 0 0 0", state_o, starve_cnt_o, force_i_o);
    end
    tests_run++;
    if (bif.ramREN !== 1'b0 || bif.ramWEN !== 1'b0 || bif.iwait !== 1'b1 || bif.dwait !== 1'b1 ||
        bif.ramaddr !== 32'h0 || bif.ramstore !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ren=%b wen=%b iw=%b dw=%b a=%h s=%h, want 0 0 1 1 0 0",
               bif.ramREN, bif.ramWEN, bif.iwait, bif.dwait, bif.ramaddr, bif.ramstore);
    end
    next_cycle();
    drop_all();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_lone_fetch();
    logic exp_iwait;
    busy_cfg = 2; err_cfg = 0; ram_data = 32'hDEADBEEF;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    bif.iREN = 1'b1; bif.iaddr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bif.dwait !== 1'b1) begin
        tests_failed++;
        $display("FAIL lone_dwait c=%0d: got %b, want 1", c, bif.dwait);
      end
      tests_run++;
      if (c == 0) begin
        if (bif.ramREN !== 1'b0) begin
          tests_failed++;
          $display("FAIL lone_bubble: got ramREN=%b, want 0", bif.ramREN);
        end
      end else if (bif.ramREN !== 1'b1 || bif.ramWEN !== 1'b0 || bif.ramaddr !== 32'h40) begin
        tests_failed++;
        $display("FAIL lone_ram c=%0d: got ren=%b wen=%b a=%h, want 1 0 00000040",
                 c, bif.ramREN, bif.ramWEN, bif.ramaddr);
      end
      exp_iwait = (c == 3) ? 1'b0 : 1'b1;
      tests_run++;
      if (bif.iwait !== exp_iwait) begin
        tests_failed++;
        $display("FAIL lone_iwait c=%0d: got %b, want %b", c, bif.iwait, exp_iwait);
      end
      next_cycle();
    end
    drop_all();
    @(negedge clk);
    tests_run++;
    if (state_o !== IDLE) begin
      tests_failed++;
      $display("FAIL lone_return_idle: got st=%0d, want 0", state_o);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    int cyc;
    busy_cfg = 1; err_cfg = 0; ram_data = 32'h11112222;
    exp_q.push_back({1'b1, 32'h11112222});
    bif.iREN = 1'b1; bif.iaddr = 32'h80; bif.dREN = 1'b1; bif.daddr = 32'h200;
    wait_done(1'b1, 10, cyc);
    tests_run++;
    if (cyc !== 2) begin
      tests_failed++;
      $display("FAIL simul_dfirst: got dcache done at cycle %0d, want 2", cyc);
    end
    bif.dREN = 1'b0;
    ram_data = 32'h33334444;
    exp_q.push_back({1'b0, 32'h33334444});
    @(negedge clk);
    tests_run++;
    if (starve_cnt_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL simul_cnt_inc: got cnt=%0d, want 1", starve_cnt_o);
    end
    next_cycle();
    wait_done(1'b0, 10, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL simul_ithen: got icache done %0d cycles after IDLE+1, want 1", cyc);
    end
    drop_all();
    @(negedge clk);
    tests_run++;
    if (starve_cnt_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL simul_cnt_clr: got cnt=%0d, want 0", starve_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_write_precedence();
    busy_cfg = 1; err_cfg = 0; ram_data = 32'h0BADF00D;
    exp_q.push_back({1'b1, 32'h0BADF00D});
    bif.dREN = 1'b1; bif.dWEN = 1'b1; bif.daddr = 32'h100; bif.dstore = 32'h12345678;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bif.ramWEN !== 1'b1 || bif.ramREN !== 1'b0 || bif.ramstore !== 32'h12345678 ||
        bif.ramaddr !== 32'h100) begin
      tests_failed++;
      $display("FAIL wr_prec: got wen=%b ren=%b s=%h a=%h, want 1 0 12345678 00000100",
               bif.ramWEN, bif.ramREN, bif.ramstore, bif.ramaddr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bif.dwait !== 1'b0 || bif.iwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_done: got dwait=%b iwait=%b, want 0 1", bif.dwait, bif.iwait);
    end
    next_cycle();
    drop_all();
    next_cycle();
  endtask

  task automatic test_starvation();
    int n_d;
    int got_i;
    busy_cfg = 0; err_cfg = 0; ram_data = 32'hCAFE0001;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 32'hCAFE0001});
    exp_q.push_back({1'b0, 32'hCAFE0001});
    bif.iREN = 1'b1; bif.iaddr = 32'h44; bif.dREN = 1'b1; bif.daddr = 32'h300;
    n_d = 0; got_i = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!bif.dwait) n_d++;
      if (!bif.iwait) got_i = c;
      next_cycle();
      if (got_i >= 0) break;
    end
    drop_all();
    tests_run++;
    if (n_d !== 4) begin
      tests_failed++;
      $display("FAIL starve_dcount: got %0d dcache completions, want 4", n_d);
    end
    tests_run++;
    if (got_i !== 9) begin
      tests_failed++;
      $display("FAIL starve_icycle: got icache done at cycle %0d, want 9", got_i);
    end
    @(negedge clk);
    tests_run++;
    if (starve_cnt_o !== 4'd0 || force_i_o !== 1'b0 || state_o !== IDLE) begin
      tests_failed++;
      $display("FAIL starve_restart: got cnt=%0d f=%b st=%0d, want 0 0 0", starve_cnt_o, force_i_o, state_o);
    end
    next_cycle();
  endtask

  task automatic test_withdraw();
    busy_cfg = 5; err_cfg = 0; ram_data = 32'h55550000;
    bif.dREN = 1'b1; bif.daddr = 32'h500;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bif.ramREN !== 1'b1 || state_o !== DGNT) begin
      tests_failed++;
      $display("FAIL wd_granted: got ren=%b st=%0d, want 1 2", bif.ramREN, state_o);
    end
    next_cycle();
    bif.dREN = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bif.ramREN !== 1'b0 || bif.dwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_fall: got ren=%b dwait=%b, want 0 1", bif.ramREN, bif.dwait);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (state_o !== IDLE) begin
      tests_failed++;
      $display("FAIL wd_idle: got st=%0d, want 0", state_o);
    end
    next_cycle();
  endtask

  task automatic test_error_retry();
    logic exp_iwait;
    busy_cfg = 0; err_cfg = 3; ram_data = 32'h0E770001;
    exp_q.push_back({1'b0, 32'h0E770001});
    bif.iREN = 1'b1; bif.iaddr = 32'h60;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_iwait = (c == 4) ? 1'b0 : 1'b1;
      tests_run++;
      if (bif.iwait !== exp_iwait) begin
        tests_failed++;
        $display("FAIL err_iwait c=%0d: got %b, want %b", c, bif.iwait, exp_iwait);
      end
      if (c >= 1) begin
        tests_run++;
        if (bif.ramREN !== 1'b1 || state_o !== IGNT) begin
          tests_failed++;
          $display("FAIL err_hold c=%0d: got ren=%b st=%0d, want 1 1", c, bif.ramREN, state_o);
        end
      end
      next_cycle();
    end
    drop_all();
    err_cfg = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    busy_cfg = 6; err_cfg = 0; ram_data = 32'h77778888;
    bif.iREN = 1'b1; bif.iaddr = 32'h70; bif.dREN = 1'b1; bif.daddr = 32'h700;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (state_o !== DGNT || starve_cnt_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got st=%0d cnt=%0d, want 2 1", state_o, starve_cnt_o);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (state_o !== IDLE || starve_cnt_o !== 4'd0 || bif.ramREN !== 1'b0 || bif.ramWEN !== 1'b0 ||
        bif.iwait !== 1'b1 || bif.dwait !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_post: got st=%0d cnt=%0d ren=%b wen=%b iw=%b dw=%b, want 0 0 0 0 1 1",
               state_o, starve_cnt_o, bif.ramREN, bif.ramWEN, bif.iwait, bif.dwait);
    end
    next_cycle();
    rst = 1'b0;
    drop_all();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int  cyc;
    int  busy;
    bit  is_d;
    for (int k = 0; k < 8; k++) begin
      is_d     = 1'($urandom_range(0, 1));
      busy     = $urandom_range(0, 3);
      busy_cfg = busy; err_cfg = 0; ram_data = $urandom;
      exp_q.push_back({is_d, ram_data});
      if (is_d) begin
        bif.dREN = 1'b1; bif.dWEN = 1'($urandom_range(0, 1));
        bif.daddr = $urandom; bif.dstore = $urandom;
      end else begin
        bif.iREN = 1'b1; bif.iaddr = $urandom;
      end
      wait_done(is_d, 12, cyc);
      tests_run++;
      if (cyc !== busy + 1) begin
        tests_failed++;
        $display("FAIL b2b_latency k=%0d d=%b: got done at cycle %0d, want %0d", k, is_d, cyc, busy + 1);
      end
      drop_all();
    end
    next_cycle();
  endtask

  // ---------------- main ----------------
  initial begin
    tests_run = 0; tests_failed = 0;
    busy_cfg = 0; err_cfg = 0; ram_data = '0;
    rst = 1'b1;
    bif.iREN = 1'b0; bif.iaddr = '0;
    bif.dREN = 1'b0; bif.dWEN = 1'b0; bif.daddr = '0; bif.dstore = '0;
    next_cycle();
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_write_precedence();
    test_starvation();
    test_withdraw();
    test_error_retry();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending completions, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the shared memory port between the instruction cache and the data cache inside the cache block. Takes the `caches_if` request signals from both caches and drives a single RAM port. Grants are registered and held for the full transaction. The data cache has priority, bounded by a starvation counter so instruction fetch always makes progress.

## Interface
- `STARVE_LIMIT`, 4: consecutive dcache grants won while iREN is pending before the next free grant is forced to icache (1..15).
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iload`  out  32  fetched instruction; equals `ramload`.
- `iwait`  out  1  low only in the cycle the icache access completes.
- `dREN`, `dWEN`  in  1 each  dcache read / write request.
- `daddr`  in  32  dcache address.
- `dstore`  in  32  dcache write data.
- `dload`  out  32  read data; equals `ramload`.
- `dwait`  out  1  low only in the cycle the dcache access completes.
- `ramREN`, `ramWEN`  out  1 each  RAM read / write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states are IDLE, IGNT and DGNT; the reset state is IDLE.
- IDLE: RAM enables are 0, `ramaddr` and `ramstore` are 0, and `iwait` and `dwait` are 1. Next state:
  - DGNT if (`dREN`|`dWEN`) and the forced-icache flag is clear.
  - Otherwise IGNT if `iREN`.
  - Otherwise IDLE.
- IGNT:
  - `ramREN` = `iREN`, `ramWEN` = 0, `ramaddr` = `iaddr`.
  - On `ramstate`==ACCESS: `iwait`=0 that cycle, next state IDLE.
- DGNT:
  - `ramaddr` = `daddr` and `ramstore` = `dstore`.
  - If `dWEN`: `ramWEN`=1 and `ramREN`=0. Write wins when both are asserted.
  - Else `ramREN` = `dREN`.
  - On ACCESS: `dwait`=0 that cycle, next state IDLE.
- Withdrawal: if the owner drops all of its enables while granted, the transaction is aborted. RAM enables fall in the same cycle (combinational), the owner's wait stays 1, and the next state is IDLE.
- BUSY and FREE while granted: hold the state and keep wait at 1.
- ERROR while granted: treated as BUSY. The request is held and retried until ACCESS.
- The non-owner's wait is always 1.
- Starvation counter, 4-bit saturating:
  - Cleared on reset and on every icache grant.
  - Incremented on each IDLE→DGNT transition taken while `iREN`=1.
  - When the count reaches `STARVE_LIMIT`, the forced flag is set. The next IDLE decision with `iREN`=1 goes to IGNT even if the dcache is requesting.
  - The flag clears on entry to IGNT.
- `RST` mid-transaction: the next edge forces IDLE and clears the counter and flag. Outputs take their IDLE values from that cycle on; the in-flight RAM access is abandoned.

## Timing
- Arbitration costs one bubble. A request seen in IDLE at edge n produces RAM enables from cycle n+1.
- Minimum latency from request to wait low is 2 cycles (IDLE, then GNT with ACCESS). Total latency is 1 + the RAM service cycles.
- Wait outputs and RAM outputs are combinational from the registered state plus current inputs. There is no combinational path from `ramstate` to the RAM enables.
- The state returns to IDLE after every completion, so back-to-back transfers from one cache are spaced at least 2 cycles apart.
- The cache must hold its address and data stable while its wait is high.

## Structure
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- Add `arb_state_t` (IDLE, IGNT, DGNT) to `cpu_types_pkg` so the cache block and bench share the encoding.
- One sub-module, `arb_starve_cnt`: a saturating counter with clear, increment and `limit` output, parameterised by `STARVE_LIMIT`.
- The top level holds the FSM and the output muxes. It is instantiated in the cache block between `icache`/`dcache` and `cif`.

## Test plan
- Lone fetch: `iREN`=1 with `iaddr`=0x40, RAM returns ACCESS after 2 BUSY cycles with `ramload`=0xDEADBEEF → `ramREN`=1 with `ramaddr`=0x40 from cycle 1; `iwait`=0 in cycle 3 with `iload`=0xDEADBEEF; `dwait`=1 throughout.
- Simultaneous requests: `iREN`=1 and `dREN`=1 in the same cycle → DGNT first, `dwait` pulses low; then IGNT and `iwait` pulses low 2+ cycles later.
- Write precedence: `dREN`=`dWEN`=1 with `daddr`=0x100 and `dstore`=0x12345678 → `ramWEN`=1, `ramREN`=0, `ramstore`=0x12345678.
- Starvation: `dREN` held with `iREN`=1 and RAM ACCESS every cycle it is requested → exactly 4 dcache completions, then an icache completion, then the counter restarts from 0.
- Withdrawal and ERROR: the granted dcache drops `dREN` mid-BUSY → `ramREN` falls the same cycle and the state returns to IDLE. Separately, ERROR for 3 cycles then ACCESS → wait stays 1 until ACCESS.
- Reset: assert `RST` during DGNT BUSY → the next cycle shows `ramREN`=`ramWEN`=0, `iwait`=`dwait`=1, state IDLE and counter 0.
